// File: rtl/dcache_pkg.sv
// Shared dcache tag-array dimensions and the tag controller state type.
// Imported by the tag controller, its request interface and its arbiter.
package dcache_pkg;
  localparam int DCACHE_SETS  = 32;
  localparam int DCACHE_SET_W = 5;
  localparam int DCACHE_TAG_W = 23;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } tag_ctrl_state_t;
endpackage

// File: rtl/dcache_tag_ctrl_if.sv
// Lookup / tag-update request bus between a cache pipeline and dcache_tag_ctrl.
// Both channels use valid/ready; the lookup result returns one cycle after acceptance.
interface dcache_tag_ctrl_if
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = DCACHE_SET_W,
  parameter int TAG_WIDTH  = DCACHE_TAG_W
);
  logic                  lkup_valid;
  logic                  lkup_ready;
  logic [ADDR_WIDTH-1:0] lkup_set;
  logic                  lkup_rsp_valid;
  logic [TAG_WIDTH-1:0]  lkup_rsp_tag;
  logic                  upd_valid;
  logic                  upd_ready;
  logic [ADDR_WIDTH-1:0] upd_set;
  logic [TAG_WIDTH-1:0]  upd_tag;

  modport master (
    output lkup_valid, lkup_set, upd_valid, upd_set, upd_tag,
    input  lkup_ready, lkup_rsp_valid, lkup_rsp_tag, upd_ready
  );

  modport slave (
    input  lkup_valid, lkup_set, upd_valid, upd_set, upd_tag,
    output lkup_ready, lkup_rsp_valid, lkup_rsp_tag, upd_ready
  );
endinterface

// File: rtl/dcache_tag_arb.sv
// Two-requester arbiter for the single SRAM port: update wins a contention unless the
// previous contended lookup lost, so a lookup never waits more than one cycle. Grants are combinational.
module dcache_tag_arb
  import dcache_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic lkup_req,
  input  logic upd_req,
  output logic lkup_gnt,
  output logic upd_gnt
);
  logic age;

  always_comb begin
    lkup_gnt = en & lkup_req & (~upd_req | age);
    upd_gnt  = en & upd_req & ~lkup_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= 1'b0;
    end else if (lkup_gnt) begin
      age <= 1'b0;
    end else if (en & lkup_req) begin
      age <= 1'b1;
    end
  end
endmodule

// File: rtl/dcache_tag_ctrl.sv
// Tag-array controller in front of a 1-port SRAM: optional zeroing sweep (DCACHE_TAG_INIT_SWEEP_EN),
// then arbitrated lookups (tag returned 1 cycle later) and updates; SRAM pins driven combinationally.
module dcache_tag_ctrl
  import dcache_pkg::*;
#(
  parameter int SETS       = DCACHE_SETS,
  parameter int ADDR_WIDTH = DCACHE_SET_W,
  parameter int TAG_WIDTH  = DCACHE_TAG_W
)(
  input  logic                  clk,
  input  logic                  rst_n,
  dcache_tag_ctrl_if.slave      bus,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [TAG_WIDTH-1:0]  sram_din0,
  input  logic [TAG_WIDTH-1:0]  sram_dout0
);
  localparam logic [ADDR_WIDTH-1:0] LAST_SET = ADDR_WIDTH'(SETS - 1);

`ifdef DCACHE_TAG_INIT_SWEEP_EN
  localparam tag_ctrl_state_t RST_STATE = INIT;
  localparam logic            RST_DONE  = 1'b0;
`else
  localparam tag_ctrl_state_t RST_STATE = RUN;
  localparam logic            RST_DONE  = 1'b1;
`endif

  tag_ctrl_state_t       state;
  logic [ADDR_WIDTH-1:0] sweep_idx;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  done_q;
  logic                  disarm;
  logic                  rsp_valid_q;
  logic                  run;
  logic                  sweep_wr;
  logic                  lkup_gnt;
  logic                  upd_gnt;

  // rst_n gates the combinational paths so nothing reaches the SRAM or the requesters while held in reset.
  assign run      = rst_n & (state == RUN);
  assign sweep_wr = rst_n & (state == INIT);

  dcache_tag_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (run),
    .lkup_req (bus.lkup_valid),
    .upd_req  (bus.upd_valid),
    .lkup_gnt (lkup_gnt),
    .upd_gnt  (upd_gnt)
  );

  assign bus.lkup_ready     = lkup_gnt;
  assign bus.upd_ready      = upd_gnt;
  assign bus.lkup_rsp_valid = rsp_valid_q;
  assign bus.lkup_rsp_tag   = sram_dout0;
  assign init_done          = done_q & rst_n;

  // Priority: sweep write, granted update, granted lookup, then the post-write disarm read.
  always_comb begin
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    if (sweep_wr) begin
      sram_csb0  = 1'b0;
      sram_web0  = 1'b0;
      sram_addr0 = sweep_idx;
    end else if (upd_gnt) begin
      sram_csb0  = 1'b0;
      sram_web0  = 1'b0;
      sram_addr0 = bus.upd_set;
      sram_din0  = bus.upd_tag;
    end else if (lkup_gnt) begin
      sram_csb0  = 1'b0;
      sram_addr0 = bus.lkup_set;
    end else if (disarm) begin
      sram_csb0  = 1'b0;
      sram_addr0 = last_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RST_STATE;
      sweep_idx   <= '0;
      done_q      <= RST_DONE;
      disarm      <= 1'b0;
      last_addr   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= lkup_gnt;
      disarm      <= sweep_wr | upd_gnt;
      if (sweep_wr) begin
        last_addr <= sweep_idx;
      end else if (upd_gnt) begin
        last_addr <= bus.upd_set;
      end
      case (state)
        INIT: begin
          if (sweep_idx == LAST_SET) begin
            sweep_idx <= '0;
            state     <= RUN;
            done_q    <= 1'b1;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
      endcase
    end
  end
endmodule

// File: doc/dcache_tag_ctrl.md
DCACHE_TAG_CTRL -- requirements
Module: dcache_tag_ctrl

Interface
REQ-001 SHALL have parameter SETS, default 32, number of tag sets.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, equal to log2(SETS).
REQ-003 SHALL have parameter TAG_WIDTH, default 23, tag word width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports lkup_valid/lkup_ready  input/output  1  lookup handshake.
REQ-007 SHALL have port lkup_set  input  ADDR_WIDTH  lookup set index.
REQ-008 SHALL have ports lkup_rsp_valid/lkup_rsp_tag  output  1/TAG_WIDTH  lookup result.
REQ-009 SHALL have ports upd_valid/upd_ready  input/output  1  tag-write handshake.
REQ-010 SHALL have ports upd_set/upd_tag  input  ADDR_WIDTH/TAG_WIDTH  write set and data.
REQ-011 SHALL have port init_done  output  1  high once the tag array is usable.
REQ-012 SHALL have ports sram_csb0/sram_web0  output  1  active-low SRAM select and write enable.
REQ-013 SHALL have ports sram_addr0/sram_din0  output  ADDR_WIDTH/TAG_WIDTH  SRAM address and write data.
REQ-014 SHALL have port sram_dout0  input  TAG_WIDTH  SRAM read data.

Function
REQ-015 SHALL register SRAM-facing outputs? No: SHALL drive sram_* combinationally from the granted request in the same cycle.
REQ-016 SHALL use FSM states INIT and RUN; INIT->RUN when the sweep writes set SETS-1; RUN is held until reset.
REQ-017 In INIT, SHALL write TAG_WIDTH'b0 to sets 0..SETS-1, one per cycle, in ascending order; lkup_ready=upd_ready=0.
REQ-018 SHALL assert init_done in the cycle after the last sweep write, and hold it until reset.
REQ-019 A transfer SHALL occur when valid and ready are both high on a rising clk edge.
REQ-020 In RUN, with only one requester valid, that requester SHALL be ready.
REQ-021 With both valid, update SHALL win unless lookup lost the previous contention (age bit set), in which case lookup wins.
REQ-022 The age bit SHALL be set on a lost lookup, cleared on a granted lookup, and reset to 0.
REQ-023 An accepted lookup SHALL produce lkup_rsp_valid=1 exactly one cycle later with lkup_rsp_tag=sram_dout0; otherwise lkup_rsp_valid=0.
REQ-024 A lookup accepted the cycle after an update to the same set SHALL return the updated tag.
REQ-025 In the cycle after any write (sweep or update) with no request granted, SHALL issue a disarm read: csb0=0, web0=1, addr0=previous address; lkup_rsp_valid stays 0.
REQ-026 Otherwise, idle cycles SHALL drive csb0=1, web0=1, addr0=0, din0=0.
REQ-027 SHALL accept back-to-back requests every cycle with no bubbles.

Reset
REQ-028 On rst_n low, SHALL immediately enter INIT with sweep index 0: init_done=0, lkup_rsp_valid=0, lkup_ready=0, upd_ready=0, csb0=1, web0=1, and the age and disarm flags cleared.
REQ-029 Reset during a sweep or an outstanding lookup SHALL drop the response and restart the sweep from set 0 after release.

Configuration
REQ-030 With DCACHE_TAG_INIT_SWEEP_EN defined, SHALL perform the REQ-017 sweep after reset.
REQ-031 Without DCACHE_TAG_INIT_SWEEP_EN, SHALL leave reset directly in RUN with init_done=1 from the first cycle, and SHALL NOT perform any sweep writes.

Structure
REQ-032 Shared package dcache_pkg SHALL hold DCACHE_SETS, DCACHE_SET_W, DCACHE_TAG_W and the tag_ctrl_state_t enum (INIT, RUN).
REQ-033 SHALL contain one sub-module, dcache_tag_arb: two-requester aged-priority arbiter (REQ-021/022).

Verification
REQ-034 Release reset with the sweep enabled -> 32 writes to sets 0..31 with din=0; init_done rises in cycle 33; one disarm read follows.
REQ-035 Update set 5 with 0x1ABCDE; next cycle lookup set 5 -> one cycle later, lkup_rsp_valid=1 with tag 0x1ABCDE.
REQ-036 lkup_valid and upd_valid held high for 6 cycles -> grants alternate U,L,U,L,U,L; no lookup waits more than 1 cycle.
REQ-037 Lookups to sets 0,1,2 on consecutive cycles -> responses on 3 consecutive cycles, in order, with the matching tags.
REQ-038 Assert rst_n low mid-sweep at set 17 and during an outstanding lookup -> outputs reset at once; no response; sweep restarts at set 0.
REQ-039 Build without DCACHE_TAG_INIT_SWEEP_EN -> init_done=1 and lkup_ready=1 in the first cycle after reset; no SRAM writes.
